// File: rtl/axi4l_timer_pkg.sv
// Shared constants, state encodings and byte-merge helpers for the AXI4-Lite timer.
package axi4l_timer_pkg;

   localparam logic [7:0] REG_CTRL    = 8'h00;
   localparam logic [7:0] REG_COUNT   = 8'h04;
   localparam logic [7:0] REG_COMPARE = 8'h08;
   localparam logic [7:0] REG_STATUS  = 8'h0C;

   localparam int unsigned CTRL_ENABLE      = 0;
   localparam int unsigned CTRL_IRQ_EN      = 1;
   localparam int unsigned CTRL_AUTO_RELOAD = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] m;
      m = strb_mask(strb);
      return (old_val & ~m) | (new_val & m);
   endfunction

endpackage

// File: rtl/axi4l_timer_if.sv
// Five-channel AXI4-Lite bundle plus the timer interrupt line.
interface axi4l_timer_if;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic [2:0]  ar_prot;
   logic        aw_valid;
   logic        aw_ready;
   logic [31:0] aw_addr;
   logic [2:0]  aw_prot;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_data;
   logic        wd_valid;
   logic        wd_ready;
   logic [31:0] wd_data;
   logic [3:0]  wstrb;
   logic        wr_valid;
   logic        wr_ready;
   logic [1:0]  wr_breap;
   logic        irq;

   modport slave (
      input  ar_valid, ar_addr, ar_prot, aw_valid, aw_addr, aw_prot,
             rd_ready, wd_valid, wd_data, wstrb, wr_ready,
      output ar_ready, aw_ready, rd_valid, rd_data, wd_ready, wr_valid, wr_breap, irq
   );

   modport master (
      output ar_valid, ar_addr, ar_prot, aw_valid, aw_addr, aw_prot,
             rd_ready, wd_valid, wd_data, wstrb, wr_ready,
      input  ar_ready, aw_ready, rd_valid, rd_data, wd_ready, wr_valid, wr_breap, irq
   );
endinterface

// File: rtl/axi4l_timer_core.sv
// Prescaler, COUNT/COMPARE registers and sticky match flag; software writes arrive pre-merged.
module timer_core #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        auto_reload,
   input  logic        count_we,
   input  logic [31:0] count_wdata,
   input  logic        compare_we,
   input  logic [31:0] compare_wdata,
   input  logic        match_clr,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        match
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [15:0] pre_q, pre_d;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        match_q, match_d;
   logic        tick;
   logic        hit;

   always_comb begin
      pre_d     = pre_q;
      count_d   = count_q;
      compare_d = compare_q;
      match_d   = match_q;
      tick      = 1'b0;
      hit       = (count_q == compare_q);

      if (!enable) begin
         pre_d = '0;
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
         tick  = 1'b1;
      end else begin
         pre_d = pre_q + 16'd1;
      end

      // Clear is applied before set so a coincident new match survives.
      if (match_clr) match_d = 1'b0;
      if (tick) begin
         if (hit) match_d = 1'b1;
         count_d = (auto_reload && hit) ? '0 : count_q + 32'd1;
      end
      if (count_we)   count_d   = count_wdata;
      if (compare_we) compare_d = compare_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q     <= '0;
         count_q   <= '0;
         compare_q <= '1;
         match_q   <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         match_q   <= match_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign match   = match_q;

endmodule

// File: rtl/axi4l_timer.sv
// AXI4-Lite responder for the timer: independent read/write channel FSMs, AW/W buffers, decode.
module axi4l_timer
   import axi4l_timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic           clk,
   input  logic           reset,
   axi4l_timer_if.slave   bus
);

   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   logic        aw_full_q, aw_full_d;
   logic [5:0]  aw_addr_q, aw_addr_d;
   logic        wd_full_q, wd_full_d;
   logic [31:0] wd_data_q, wd_data_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  wr_resp_q, wr_resp_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic        aw_ready, wd_ready, wr_valid, ar_ready, rd_valid;
   logic        aw_hs, wd_hs;
   logic [5:0]  w_addr;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic [31:0] ctrl_wdata;
   logic [31:0] count_wdata, compare_wdata;
   logic        count_we, compare_we, match_clr;
   logic [31:0] rd_mux;

   logic [31:0] count, compare;
   logic        match;

   timer_core #(.PRESCALE(PRESCALE)) u_core (
      .clk           (clk),
      .reset         (reset),
      .enable        (ctrl_q[CTRL_ENABLE]),
      .auto_reload   (ctrl_q[CTRL_AUTO_RELOAD]),
      .count_we      (count_we),
      .count_wdata   (count_wdata),
      .compare_we    (compare_we),
      .compare_wdata (compare_wdata),
      .match_clr     (match_clr),
      .count         (count),
      .compare       (compare),
      .match         (match)
   );

   // A buffered beat takes precedence over the live bus since the bus beat can't be accepted then.
   always_comb begin
      w_addr        = aw_full_q ? aw_addr_q : bus.aw_addr[7:2];
      w_data        = wd_full_q ? wd_data_q : bus.wd_data;
      w_strb        = wd_full_q ? wstrb_q   : bus.wstrb;
      ctrl_wdata    = merge_bytes({29'b0, ctrl_q}, w_data, w_strb);
      count_wdata   = merge_bytes(count, w_data, w_strb);
      compare_wdata = merge_bytes(compare, w_data, w_strb);
   end

   always_comb begin
      w_state_d  = w_state_q;
      aw_full_d  = aw_full_q;
      aw_addr_d  = aw_addr_q;
      wd_full_d  = wd_full_q;
      wd_data_d  = wd_data_q;
      wstrb_d    = wstrb_q;
      wr_resp_d  = wr_resp_q;
      ctrl_d     = ctrl_q;
      count_we   = 1'b0;
      compare_we = 1'b0;
      match_clr  = 1'b0;
      aw_ready   = 1'b0;
      wd_ready   = 1'b0;
      wr_valid   = 1'b0;
      aw_hs      = 1'b0;
      wd_hs      = 1'b0;

      case (w_state_q)
         W_IDLE: begin
            aw_ready = ~aw_full_q;
            wd_ready = ~wd_full_q;
            aw_hs    = bus.aw_valid & aw_ready;
            wd_hs    = bus.wd_valid & wd_ready;
            if (aw_hs) begin
               aw_full_d = 1'b1;
               aw_addr_d = bus.aw_addr[7:2];
            end
            if (wd_hs) begin
               wd_full_d = 1'b1;
               wd_data_d = bus.wd_data;
               wstrb_d   = bus.wstrb;
            end
            if ((aw_full_q || aw_hs) && (wd_full_q || wd_hs)) begin
               w_state_d = W_RESP;
               wr_resp_d = RESP_OKAY;
               case ({w_addr, 2'b00})
                  REG_CTRL:    ctrl_d     = ctrl_wdata[2:0];
                  REG_COUNT:   count_we   = 1'b1;
                  REG_COMPARE: compare_we = 1'b1;
                  REG_STATUS:  match_clr  = w_strb[0] & w_data[0];
                  default:     wr_resp_d  = RESP_SLVERR;
               endcase
            end
         end
         W_RESP: begin
            wr_valid = 1'b1;
            if (bus.wr_ready) begin
               w_state_d = W_IDLE;
               aw_full_d = 1'b0;
               wd_full_d = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      case ({bus.ar_addr[7:2], 2'b00})
         REG_CTRL:    rd_mux = {29'b0, ctrl_q};
         REG_COUNT:   rd_mux = count;
         REG_COMPARE: rd_mux = compare;
         REG_STATUS:  rd_mux = {31'b0, match};
         default:     rd_mux = '0;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rd_data_d = rd_data_q;
      ar_ready  = 1'b0;
      rd_valid  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (bus.ar_valid) begin
               rd_data_d = rd_mux;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            rd_valid = 1'b1;
            if (bus.rd_ready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         wd_full_q <= 1'b0;
         wd_data_q <= '0;
         wstrb_q   <= '0;
         wr_resp_q <= RESP_OKAY;
         ctrl_q    <= '0;
         rd_data_q <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         wd_full_q <= wd_full_d;
         wd_data_q <= wd_data_d;
         wstrb_q   <= wstrb_d;
         wr_resp_q <= wr_resp_d;
         ctrl_q    <= ctrl_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign bus.ar_ready = ar_ready;
   assign bus.aw_ready = aw_ready;
   assign bus.wd_ready = wd_ready;
   assign bus.rd_valid = rd_valid;
   assign bus.rd_data  = rd_data_q;
   assign bus.wr_valid = wr_valid;
   assign bus.wr_breap = wr_resp_q;
   assign bus.irq      = match & ctrl_q[CTRL_IRQ_EN];

   logic unused_bits;
   assign unused_bits = ^{bus.ar_addr[31:8], bus.ar_addr[1:0], bus.aw_addr[31:8],
                          bus.aw_addr[1:0], bus.ar_prot, bus.aw_prot, ctrl_wdata[31:3]};

endmodule

// File: tb/tb_axi4l_timer.sv
// Directed bench for axi4l_timer with PRESCALE=4: reset, split AW/W, strobes, counter/irq, errors, hold.
module tb_axi4l_timer;
   import axi4l_timer_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   axi4l_timer_if bus();

   axi4l_timer #(.PRESCALE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      bus.aw_valid = 1'b1; bus.aw_addr = addr;
      bus.wd_valid = 1'b1; bus.wd_data = data; bus.wstrb = strb;
      step();
      bus.aw_valid = 1'b0; bus.wd_valid = 1'b0;
      for (int i = 0; i < 20 && !bus.wr_valid; i++) step();
      if (!bus.wr_valid) begin
         n_cmp++; n_err++;
         $display("FAIL write_timeout addr=%h wr_valid got 0 want 1", addr);
      end
      resp = bus.wr_breap;
      bus.wr_ready = 1'b1;
      step();
      bus.wr_ready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
      bus.ar_valid = 1'b1; bus.ar_addr = addr;
      step();
      bus.ar_valid = 1'b0;
      for (int i = 0; i < 20 && !bus.rd_valid; i++) step();
      if (!bus.rd_valid) begin
         n_cmp++; n_err++;
         $display("FAIL read_timeout addr=%h rd_valid got 0 want 1", addr);
      end
      data = bus.rd_data;
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [8:0]  flags;
      flags = {bus.ar_ready, bus.aw_ready, bus.wd_ready, bus.rd_valid, bus.wr_valid,
               bus.wr_breap, bus.irq, |bus.rd_data};
      n_cmp++;
      if (flags !== 9'b1_1100_0000) begin
         n_err++; $display("FAIL reset_outputs got %b want 111000000", flags);
      end
      do_read(32'h08, d);
      n_cmp++;
      if (d !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL reset_compare got %h want ffffffff", d);
      end
      do_read(32'h00, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL reset_ctrl got %h want 00000000", d);
      end
   endtask

   task automatic test_aw_before_w();
      logic [31:0] d;
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h04;
      step();
      bus.aw_valid = 1'b0;
      n_cmp++;
      if (bus.aw_ready !== 1'b0) begin
         n_err++; $display("FAIL aw_buffered_ready got %b want 0", bus.aw_ready);
      end
      step();
      step();
      n_cmp++;
      if (bus.wr_valid !== 1'b0) begin
         n_err++; $display("FAIL aw_only_wr_valid got %b want 0", bus.wr_valid);
      end
      bus.wd_valid = 1'b1; bus.wd_data = 32'h12; bus.wstrb = 4'hF;
      step();
      bus.wd_valid = 1'b0;
      n_cmp++;
      if ({bus.wr_valid, bus.wr_breap} !== {1'b1, RESP_OKAY}) begin
         n_err++; $display("FAIL split_write_resp got %b%b want 100", bus.wr_valid, bus.wr_breap);
      end
      bus.wr_ready = 1'b1;
      step();
      bus.wr_ready = 1'b0;
      n_cmp++;
      if ({bus.wr_valid, bus.aw_ready, bus.wd_ready} !== 3'b011) begin
         n_err++; $display("FAIL split_write_done got %b%b%b want 011",
                           bus.wr_valid, bus.aw_ready, bus.wd_ready);
      end
      do_read(32'h04, d);
      n_cmp++;
      if (d !== 32'h12) begin
         n_err++; $display("FAIL count_readback got %h want 00000012", d);
      end
   endtask

   task automatic test_strobe();
      logic [31:0] d;
      logic [1:0]  r;
      do_write(32'h08, 32'hAABB_CCDD, 4'b0101, r);
      n_cmp++;
      if (r !== RESP_OKAY) begin
         n_err++; $display("FAIL strobe_resp got %b want 00", r);
      end
      do_read(32'h08, d);
      n_cmp++;
      if (d !== 32'hFFBB_FFDD) begin
         n_err++; $display("FAIL strobe_merge got %h want ffbbffdd", d);
      end
   endtask

   task automatic test_counter();
      logic [1:0]  r;
      logic [31:0] exp_cnt [5];
      exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
      do_write(32'h04, 32'h0, 4'hF, r);
      do_write(32'h08, 32'h3, 4'hF, r);
      // Enable write commits at edge E; loop index n means "just after edge E+n".
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h00;
      bus.wd_valid = 1'b1; bus.wd_data = 32'h7; bus.wstrb = 4'hF;
      step();
      bus.aw_valid = 1'b0; bus.wd_valid = 1'b0;
      bus.wr_ready = 1'b1;
      for (int n = 1; n <= 22; n++) begin
         step();
         if (n == 1) bus.wr_ready = 1'b0;
         if (n inside {2, 6, 10, 14, 18}) begin
            bus.ar_valid = 1'b1; bus.ar_addr = 32'h04;
         end
         if (n inside {3, 7, 11, 15, 19}) begin
            bus.ar_valid = 1'b0;
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_cnt[(n - 3) / 4]) begin
               n_err++;
               $display("FAIL count_seq_n%0d got valid=%b data=%h want valid=1 data=%h",
                        n - 1, bus.rd_valid, bus.rd_data, exp_cnt[(n - 3) / 4]);
            end
            bus.rd_ready = 1'b1;
         end
         if (n inside {4, 8, 12, 16, 20}) bus.rd_ready = 1'b0;
         if (n == 15 || n == 16 || n == 19) begin
            n_cmp++;
            if (bus.irq !== (n != 15)) begin
               n_err++; $display("FAIL irq_n%0d got %b want %b", n, bus.irq, n != 15);
            end
         end
         if (n == 20) begin
            bus.aw_valid = 1'b1; bus.aw_addr = 32'h0C;
            bus.wd_valid = 1'b1; bus.wd_data = 32'h1; bus.wstrb = 4'h1;
         end
         if (n == 21) begin
            bus.aw_valid = 1'b0; bus.wd_valid = 1'b0;
            n_cmp++;
            if ({bus.irq, bus.wr_valid} !== 2'b01) begin
               n_err++; $display("FAIL w1c_irq got irq=%b wr_valid=%b want irq=0 wr_valid=1",
                                 bus.irq, bus.wr_valid);
            end
            bus.wr_ready = 1'b1;
         end
         if (n == 22) bus.wr_ready = 1'b0;
      end
      do_write(32'h00, 32'h0, 4'hF, r);
   endtask

   task automatic test_bad_addr();
      logic [31:0] d;
      logic [1:0]  r;
      do_write(32'h20, 32'hFFFF_FFFF, 4'hF, r);
      n_cmp++;
      if (r !== RESP_SLVERR) begin
         n_err++; $display("FAIL bad_write_resp got %b want 10", r);
      end
      do_read(32'h20, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL bad_read_data got %h want 00000000", d);
      end
      do_read(32'h08, d);
      n_cmp++;
      if (d !== 32'h3) begin
         n_err++; $display("FAIL bad_write_side_effect got %h want 00000003", d);
      end
      do_write(32'h00, 32'hFFFF_FFF8, 4'hF, r);
      do_read(32'h00, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL ctrl_reserved_bits got %h want 00000000", d);
      end
   endtask

   task automatic test_back_to_back();
      bus.ar_valid = 1'b1; bus.ar_addr = 32'h08; bus.rd_ready = 1'b1;
      step();
      n_cmp++;
      if ({bus.rd_valid, bus.ar_ready} !== 2'b10 || bus.rd_data !== 32'h3) begin
         n_err++; $display("FAIL b2b_first got valid=%b ar_ready=%b data=%h want 1 0 00000003",
                           bus.rd_valid, bus.ar_ready, bus.rd_data);
      end
      step();
      n_cmp++;
      if ({bus.rd_valid, bus.ar_ready} !== 2'b01) begin
         n_err++; $display("FAIL b2b_gap got valid=%b ar_ready=%b want 0 1",
                           bus.rd_valid, bus.ar_ready);
      end
      step();
      bus.ar_valid = 1'b0;
      n_cmp++;
      if (bus.rd_valid !== 1'b1) begin
         n_err++; $display("FAIL b2b_second got %b want 1", bus.rd_valid);
      end
      step();
      bus.rd_ready = 1'b0;
   endtask

   task automatic test_hold_and_reset();
      logic [31:0] d;
      bus.ar_valid = 1'b1; bus.ar_addr = 32'h08;
      bus.aw_valid = 1'b1; bus.aw_addr = 32'h20;
      bus.wd_valid = 1'b1; bus.wd_data = 32'h0; bus.wstrb = 4'hF;
      step();
      bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.wd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({bus.rd_valid, bus.wr_valid, bus.wr_breap, bus.ar_ready, bus.aw_ready} !== 6'b111000
             || bus.rd_data !== 32'h3) begin
            n_err++;
            $display("FAIL hold_c%0d got rv=%b wv=%b resp=%b ar=%b aw=%b data=%h want 1 1 10 0 0 00000003",
                     i, bus.rd_valid, bus.wr_valid, bus.wr_breap, bus.ar_ready, bus.aw_ready,
                     bus.rd_data);
         end
         step();
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.rd_valid, bus.wr_valid, bus.ar_ready, bus.aw_ready, bus.wd_ready} !== 5'b00111) begin
         n_err++; $display("FAIL async_reset got %b%b%b%b%b want 00111", bus.rd_valid,
                           bus.wr_valid, bus.ar_ready, bus.aw_ready, bus.wd_ready);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      do_read(32'h08, d);
      n_cmp++;
      if (d !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL post_reset_compare got %h want ffffffff", d);
      end
   endtask

   initial begin
      bus.ar_valid = 1'b0; bus.ar_addr = '0; bus.ar_prot = '0;
      bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_prot = '0;
      bus.wd_valid = 1'b0; bus.wd_data = '0; bus.wstrb = '0;
      bus.rd_ready = 1'b0; bus.wr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      test_reset();
      test_aw_before_w();
      test_strobe();
      test_counter();
      test_bad_addr();
      test_back_to_back();
      test_hold_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
